// File: rtl/bch_correct_buffer.sv
// Serial correction buffer: stores received data frames, XORs them with the
// err stream from bch_error and replays the corrected bits in order.
module bch_correct_buffer #(
   parameter int DATA_BITS = 8,
   parameter int FRAMES    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic in_start,
   input  logic in_valid,
   input  logic in_data,
   input  logic err_first,
   input  logic err_valid,
   input  logic err,
   output logic out_valid,
   output logic out_first,
   output logic out_last,
   output logic out_data,
   output logic full,
   output logic overflow,
   output logic sync_err
);

   localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int PTR_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam int COM_W = $clog2(FRAMES + 1);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [COM_W-1:0] com_t;

   localparam cnt_t LAST_BIT = cnt_t'(DATA_BITS - 1);
   localparam com_t COM_MAX  = com_t'(FRAMES);

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(FRAMES - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   logic [DATA_BITS-1:0] store [FRAMES];

   ptr_t wr_frame, wr_frame_nxt, rd_frame, rd_frame_nxt, rd_slot;
   cnt_t wr_cnt, wr_cnt_nxt, rd_cnt, rd_cnt_nxt, wr_bit, rd_bit;
   com_t committed, committed_nxt;
   logic wr_en, commit, drop;
   logic rd_fire, release_cur, sync_set;

   // NOTE: every signal gets a default before the decode so no latch is inferred.
   always_comb begin
      wr_en        = 1'b0;
      wr_bit       = '0;
      commit       = 1'b0;
      drop         = 1'b0;
      wr_cnt_nxt   = wr_cnt;
      wr_frame_nxt = wr_frame;
      if (in_valid) begin
         if (in_start) begin
            if (committed == COM_MAX) begin
               drop       = 1'b1;
               wr_cnt_nxt = '0;
            end else begin
               // A start mid-frame simply restarts the same slot at bit 0.
               wr_en      = 1'b1;
               wr_cnt_nxt = cnt_t'(1);
            end
         end else if (wr_cnt != '0) begin
            wr_en  = 1'b1;
            wr_bit = wr_cnt;
            if (wr_cnt == LAST_BIT) begin
               commit       = 1'b1;
               wr_cnt_nxt   = '0;
               wr_frame_nxt = ptr_inc(wr_frame);
            end else begin
               wr_cnt_nxt = wr_cnt + cnt_t'(1);
            end
         end
      end
   end

   always_comb begin
      rd_fire      = 1'b0;
      release_cur  = 1'b0;
      sync_set     = 1'b0;
      rd_slot      = rd_frame;
      rd_bit       = rd_cnt;
      rd_frame_nxt = rd_frame;
      rd_cnt_nxt   = rd_cnt;
      if (err_valid) begin
         if (committed == '0) begin
            sync_set = 1'b1;
         end else if (err_first && rd_cnt != '0) begin
            // Drop the half-read frame; this err bit opens the next one if stored.
            sync_set     = 1'b1;
            release_cur  = 1'b1;
            rd_frame_nxt = ptr_inc(rd_frame);
            rd_cnt_nxt   = '0;
            if (committed > com_t'(1)) begin
               rd_fire    = 1'b1;
               rd_slot    = ptr_inc(rd_frame);
               rd_bit     = '0;
               rd_cnt_nxt = cnt_t'(1);
            end
         end else if (!err_first && rd_cnt == '0) begin
            sync_set = 1'b1;
         end else begin
            rd_fire = 1'b1;
            if (rd_cnt == LAST_BIT) begin
               release_cur  = 1'b1;
               rd_frame_nxt = ptr_inc(rd_frame);
               rd_cnt_nxt   = '0;
            end else begin
               rd_cnt_nxt = rd_cnt + cnt_t'(1);
            end
         end
      end
   end

   always_comb begin
      committed_nxt = committed;
      if (commit && !release_cur)
         committed_nxt = committed + com_t'(1);
      else if (!commit && release_cur)
         committed_nxt = committed - com_t'(1);
   end

   assign full = (committed == COM_MAX) ||
                 ((committed == COM_MAX - com_t'(1)) && (wr_cnt != '0));

   // NOTE: non-blocking assignments for all registered state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_frame  <= '0;
         wr_cnt    <= '0;
         rd_frame  <= '0;
         rd_cnt    <= '0;
         committed <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= 1'b0;
         overflow  <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         wr_frame  <= wr_frame_nxt;
         wr_cnt    <= wr_cnt_nxt;
         rd_frame  <= rd_frame_nxt;
         rd_cnt    <= rd_cnt_nxt;
         committed <= committed_nxt;
         out_valid <= rd_fire;
         out_first <= rd_fire && (rd_bit == '0);
         out_last  <= rd_fire && (rd_bit == LAST_BIT);
         out_data  <= rd_fire && (store[rd_slot][rd_bit] ^ err);
         if (drop)
            overflow <= 1'b1;
         if (sync_set)
            sync_err <= 1'b1;
      end
   end

   // NOTE: storage has no reset; only committed slots are ever read.
   always_ff @(posedge clk) begin
      if (wr_en)
         store[wr_frame][wr_bit] <= in_data;
   end

endmodule

// File: tb/tb_bch_correct_buffer.sv
// Scoreboard bench for bch_correct_buffer (DATA_BITS=8, FRAMES=4): directed
// frames and err patterns with hand-computed corrected outputs.
module tb_bch_correct_buffer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_start = 1'b0, in_valid = 1'b0, in_data = 1'b0;
   logic err_first = 1'b0, err_valid = 1'b0, err = 1'b0;
   logic out_valid, out_first, out_last, out_data, full, overflow, sync_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic data;
      logic first;
      logic last;
      int   due;
   } exp_t;
   exp_t sb[$];

   bch_correct_buffer #(.DATA_BITS(8), .FRAMES(4)) dut (
      .clk(clk), .reset(reset),
      .in_start(in_start), .in_valid(in_valid), .in_data(in_data),
      .err_first(err_first), .err_valid(err_valid), .err(err),
      .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
      .out_data(out_data), .full(full), .overflow(overflow), .sync_err(sync_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per presented output bit.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", out_valid, 0);
            end else begin
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               check("out_first", out_first, e.first);
               check("out_last", out_last, e.last);
               check("out_latency_cycle", cyc, e.due);
            end
         end
      end
   end

   task automatic step(input logic iv, input logic is, input logic id,
                       input logic ev, input logic ef, input logic e,
                       input logic xv = 0, input logic xd = 0,
                       input logic xf = 0, input logic xl = 0);
      @(negedge clk);
      in_valid  = iv;
      in_start  = is;
      in_data   = id;
      err_valid = ev;
      err_first = ef;
      err       = e;
      if (xv) sb.push_back('{xd, xf, xl, cyc + 1});
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic send_frame(input logic [7:0] d, input int gap_at = -1);
      for (int i = 0; i < 8; i++) begin
         if (i == gap_at) idle(1);
         step(1, i == 0, d[i], 0, 0, 0);
      end
   endtask

   task automatic read_frame(input logic [7:0] e, input logic [7:0] x, input int gap_at = -1);
      for (int i = 0; i < 8; i++) begin
         if (i == gap_at) idle(1);
         step(0, 0, 0, 1, i == 0, e[i], 1, x[i], i == 0, i == 7);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_first"}, out_first, 0);
      check({tag, "_out_last"},  out_last, 0);
      check({tag, "_out_data"},  out_data, 0);
      check({tag, "_full"},      full, 0);
      check({tag, "_overflow"},  overflow, 0);
      check({tag, "_sync_err"},  sync_err, 0);
   endtask

   initial begin
      logic [7:0] w;
      logic [7:0] r;
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;

      // 1: plain round trip, err window opens after idle cycles
      send_frame(8'hA5);
      idle(3);
      read_frame(8'h00, 8'hA5);
      idle(2);
      check("t1_overflow", overflow, 0);
      check("t1_sync_err", sync_err, 0);
      check("t1_full", full, 0);

      // 2: two flipped bits, with stalls on both sides
      send_frame(8'hA5, 4);
      read_frame(8'h81, 8'h24, 3);
      idle(2);

      // 3: fill all slots, then overflow
      send_frame(8'h01);
      send_frame(8'h02);
      send_frame(8'h03);
      idle(1);
      check("t3_full_at_3", full, 0);
      w = 8'h04;
      for (int i = 0; i < 4; i++) step(1, i == 0, w[i], 0, 0, 0);
      idle(1);
      check("t3_full_writing_4th", full, 1);
      for (int i = 4; i < 8; i++) step(1, 0, w[i], 0, 0, 0);
      idle(1);
      check("t3_full_at_4", full, 1);
      check("t3_overflow_before", overflow, 0);
      send_frame(8'h55);
      idle(1);
      check("t3_overflow_after", overflow, 1);
      read_frame(8'h00, 8'h01);
      read_frame(8'h00, 8'h02);
      read_frame(8'h00, 8'h03);
      read_frame(8'h00, 8'h04);
      idle(2);
      check("t3_full_drained", full, 0);

      // 4: err with nothing stored
      step(0, 0, 0, 1, 1, 0);
      idle(2);
      check("t4_sync_err", sync_err, 1);

      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst2_overflow", overflow, 0);
      check("rst2_sync_err", sync_err, 0);
      @(negedge clk);
      reset = 1'b0;

      // 5: commit of frame 1 coincides with reading bit 7 of frame 0
      send_frame(8'h5A);
      w = 8'hC3;
      r = 8'h5A;
      for (int i = 0; i < 8; i++)
         step(1, i == 0, w[i], 1, i == 0, 1'b0, 1, r[i], i == 0, i == 7);
      idle(1);
      check("t5_full", full, 0);
      read_frame(8'h00, 8'hC3);
      idle(2);
      check("t5_sync_err", sync_err, 0);

      // abandoned partial write and a stray bit outside a frame
      step(1, 0, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      send_frame(8'h0F);
      read_frame(8'h00, 8'h0F);
      idle(2);
      check("abandon_sync_err", sync_err, 0);

      // err_first mid-frame: 0x96 released after 3 bits, 0x3E read in full
      send_frame(8'h96);
      send_frame(8'h3E);
      step(0, 0, 0, 1, 1, 0, 1, 0, 1, 0);
      step(0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
      read_frame(8'h00, 8'h3E);
      idle(2);
      check("resync_sync_err", sync_err, 1);
      check("resync_full", full, 0);

      // err bit without err_first at frame start is discarded
      send_frame(8'h77);
      step(0, 0, 0, 1, 0, 1);
      read_frame(8'h00, 8'h77);
      idle(2);

      // 6: async reset while writing bit 4 and reading bit 2
      send_frame(8'h11);
      w = 8'hE7;
      r = 8'h11;
      for (int j = 0; j < 5; j++)
         step(1, j == 0, w[j], j >= 2, j == 2, 1'b0,
              (j == 2) || (j == 3), (j >= 2) ? r[(j >= 2) ? j - 2 : 0] : 1'b0, j == 2, 1'b0);
      #2 reset = 1'b1;
      #1;
      check_outputs_zero("async_reset");
      idle(1);
      @(negedge clk);
      reset = 1'b0;
      send_frame(8'h3C);
      read_frame(8'h00, 8'h3C);
      idle(3);
      check("t6_overflow", overflow, 0);
      check("t6_sync_err", sync_err, 0);
      check("t6_full", full, 0);
      check("scoreboard_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
